// File: rtl/mario_coin_scheduler.sv
// Coin table owner for one level: scans valid coin slots once per frame through the shared
// touch detector, clears collected coins, requests a SKY tile write and counts coins in BCD.
module mario_coin_scheduler #(
    parameter int         NUM_COINS = 16,
    parameter logic [2:0] SKY       = 3'd1,
    parameter logic [2:0] TKN       = 3'd4,
    parameter int         IDX_W     = $clog2(NUM_COINS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             frame_tick,
    input  logic             level_clear,
    input  logic             load_we,
    input  logic [IDX_W-1:0] load_idx,
    input  logic [31:0]      load_x,
    input  logic [31:0]      load_y,
    output logic [31:0]      probe_x,
    output logic [31:0]      probe_y,
    input  logic             touch_in,
    output logic             map_wr_valid,
    input  logic             map_wr_ready,
    output logic [31:0]      map_wr_x,
    output logic [31:0]      map_wr_y,
    output logic [2:0]       map_wr_tile,
    output logic [7:0]       coin_count,
    output logic             one_up,
    output logic             busy,
    output logic             scan_done,
    output logic             overrun
);

    // state | meaning
    // IDLE  | waiting for frame_tick; slot loads accepted here only
    // SETUP | one cycle per slot: skip if empty, else launch probe
    // EVAL  | phase 0 waits for the detector register, phase 1 samples touch_in
    // WRITE | holding the SKY map write until map_wr_ready
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_EVAL  = 2'd2;
    localparam logic [1:0] S_WRITE = 2'd3;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_COINS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    if (NUM_COINS < 2 || (NUM_COINS & (NUM_COINS - 1)) != 0) begin : g_bad_num_coins
        $error("NUM_COINS must be a power of two and at least 2");
    end
    if (SKY == TKN) begin : g_bad_tiles
        $error("SKY and TKN tile codes must differ");
    end

    logic [1:0]           state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 phase_q, phase_d;
    logic [NUM_COINS-1:0] slot_valid_q, slot_valid_d;
    logic [31:0]          slot_x_q [NUM_COINS];
    logic [31:0]          slot_x_d [NUM_COINS];
    logic [31:0]          slot_y_q [NUM_COINS];
    logic [31:0]          slot_y_d [NUM_COINS];
    logic [31:0]          probe_x_q, probe_x_d;
    logic [31:0]          probe_y_q, probe_y_d;
    logic                 wr_valid_q, wr_valid_d;
    logic [31:0]          wr_x_q, wr_x_d;
    logic [31:0]          wr_y_q, wr_y_d;
    logic [7:0]           count_q, count_d;
    logic                 one_up_q, one_up_d;
    logic                 busy_q, busy_d;
    logic                 scan_done_q, scan_done_d;
    logic                 overrun_q, overrun_d;
    logic                 advance;
    logic [8:0]           bcd_next;

    // Returns {wrapped_99_to_00, next_value}.
    function automatic logic [8:0] bcd_inc(input logic [7:0] v);
        logic [3:0] lo;
        logic [3:0] hi;
        logic       wrap;
        lo   = v[3:0];
        hi   = v[7:4];
        wrap = 1'b0;
        if (lo == 4'd9) begin
            lo = 4'd0;
            if (hi == 4'd9) begin
                hi   = 4'd0;
                wrap = 1'b1;
            end else begin
                hi = hi + 4'd1;
            end
        end else begin
            lo = lo + 4'd1;
        end
        return {wrap, hi, lo};
    endfunction

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        phase_d      = phase_q;
        slot_valid_d = slot_valid_q;
        slot_x_d     = slot_x_q;
        slot_y_d     = slot_y_q;
        probe_x_d    = probe_x_q;
        probe_y_d    = probe_y_q;
        wr_valid_d   = wr_valid_q;
        wr_x_d       = wr_x_q;
        wr_y_d       = wr_y_q;
        count_d      = count_q;
        one_up_d     = 1'b0;
        scan_done_d  = 1'b0;
        overrun_d    = overrun_q;
        advance      = 1'b0;
        bcd_next     = bcd_inc(count_q);

        if (level_clear) begin
            state_d      = S_IDLE;
            idx_d        = '0;
            phase_d      = 1'b0;
            slot_valid_d = '0;
            wr_valid_d   = 1'b0;
            count_d      = 8'h00;
            overrun_d    = 1'b0;
        end else begin
            if (frame_tick && state_q != S_IDLE) begin
                overrun_d = 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (load_we) begin
                        slot_valid_d[load_idx] = 1'b1;
                        slot_x_d[load_idx]     = load_x;
                        slot_y_d[load_idx]     = load_y;
                    end
                    if (frame_tick) begin
                        idx_d   = '0;
                        state_d = S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (slot_valid_q[idx_q]) begin
                        probe_x_d = slot_x_q[idx_q];
                        probe_y_d = slot_y_q[idx_q];
                        phase_d   = 1'b0;
                        state_d   = S_EVAL;
                    end else begin
                        advance = 1'b1;
                    end
                end
                S_EVAL: begin
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else if (touch_in) begin
                        slot_valid_d[idx_q] = 1'b0;
                        wr_x_d              = slot_x_q[idx_q];
                        wr_y_d              = slot_y_q[idx_q];
                        wr_valid_d          = 1'b1;
                        count_d             = bcd_next[7:0];
                        one_up_d            = bcd_next[8];
                        state_d             = S_WRITE;
                    end else begin
                        advance = 1'b1;
                    end
                end
                S_WRITE: begin
                    if (map_wr_ready) begin
                        wr_valid_d = 1'b0;
                        advance    = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase

            if (advance) begin
                if (idx_q == IDX_LAST) begin
                    state_d     = S_IDLE;
                    scan_done_d = 1'b1;
                end else begin
                    idx_d   = idx_q + IDX_ONE;
                    state_d = S_SETUP;
                end
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            phase_q      <= 1'b0;
            slot_valid_q <= '0;
            probe_x_q    <= '0;
            probe_y_q    <= '0;
            wr_valid_q   <= 1'b0;
            wr_x_q       <= '0;
            wr_y_q       <= '0;
            count_q      <= 8'h00;
            one_up_q     <= 1'b0;
            busy_q       <= 1'b0;
            scan_done_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            phase_q      <= phase_d;
            slot_valid_q <= slot_valid_d;
            probe_x_q    <= probe_x_d;
            probe_y_q    <= probe_y_d;
            wr_valid_q   <= wr_valid_d;
            wr_x_q       <= wr_x_d;
            wr_y_q       <= wr_y_d;
            count_q      <= count_d;
            one_up_q     <= one_up_d;
            busy_q       <= busy_d;
            scan_done_q  <= scan_done_d;
            overrun_q    <= overrun_d;
        end
    end

    // Coordinates are qualified by slot_valid_q, so they need no reset.
    always_ff @(posedge clk) begin
        slot_x_q <= slot_x_d;
        slot_y_q <= slot_y_d;
    end

    assign probe_x      = probe_x_q;
    assign probe_y      = probe_y_q;
    assign map_wr_valid = wr_valid_q;
    assign map_wr_x     = wr_x_q;
    assign map_wr_y     = wr_y_q;
    assign map_wr_tile  = SKY;
    assign coin_count   = count_q;
    assign one_up       = one_up_q;
    assign busy         = busy_q;
    assign scan_done    = scan_done_q;
    assign overrun      = overrun_q;

endmodule
